simple_loader: RTL and testbench

Boot-time program loader for the SIMPLE processor: the writing end of the instruction/data RAM that the core only reads during execution. Accepts a byte stream over a valid/ready handshake, assembles 16-bit big-endian words, writes them to consecutive RAM addresses from 0, and holds the core in reset until the image is complete. Sits between the host byte source (UART receiver or bench driver) and the RAM write port, and drives the core's reset input.

---
 rtl/simple_loader.sv | 127 ++++++++++++
 tb/tb_simple_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_loader.sv
// Boot-time program loader: assembles a length-prefixed big-endian byte stream
// into 16-bit words, writes them to RAM from address 0, and holds the core in reset until done.
module simple_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  // 17-bit count so a 16-bit header can be compared against a depth of up to 2^16
  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] remaining;
  logic [15:0]      len_word;
  logic             xfer;

  // Decoded from the state register only; no path from in_valid
  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DAT_HI) || (state == S_DAT_LO);
  assign xfer     = in_valid & in_ready;
  assign len_word = {hi_byte, in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN_HI;
      hi_byte   <= 8'd0;
      remaining <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_LEN_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            remaining <= CNT_W'(len_word);
            if (len_word == 16'd0) begin
              state   <= S_DONE;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else if (CNT_W'(len_word) > DEPTH) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          if (xfer) begin
            ram_wdata <= DATA_W'({hi_byte, in_data});
            ram_we    <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address wraps to 0 after a full-depth image and is not written again
          ram_addr  <= ram_addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state   <= S_DONE;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            state <= S_DAT_HI;
          end
        end
        S_DONE: begin
          if (load_req) begin
            state    <= S_LEN_HI;
            ram_addr <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_ERR: begin
          if (load_req) begin
            state    <= S_LEN_HI;
            ram_addr <= '0;
            err      <= 1'b0;
          end
        end
        default: state <= S_LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_loader.sv
// Self-checking bench for simple_loader (ADDR_W = 4): table vectors, corner sequences,
// and randomized loads checked against a stream-level reference model.
module tb_simple_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          load_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  simple_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .load_req(load_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int          nb;
    logic [7:0]  b [8];
    logic        done_e;
    logic        err_e;
    int          nw;
    logic [15:0] w [3];
    int          gap;
  } vec_t;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_we_cyc = -1;
  int   done_rise   = -1;
  logic prev_done   = 1'b0;
  wr_t  got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture each RAM write on the edge that ends the write cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && ram_we) begin
      got.push_back({ram_addr, ram_wdata});
      last_we_cyc <= cyc;
    end
    if (!rst && done && !prev_done) done_rise <= cyc;
    prev_done <= done;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
      if (ram_we) check("in_ready_low_in_write", 32'(in_ready), 32'd0);
    end
  end

  // Reference: the image a stream describes, at the level of words and addresses
  task automatic model(input logic [7:0] s[$], output wr_t w[$], output bit d, output bit e);
    int n;
    w = {};
    n = int'({s[0], s[1]});
    d = 1'b0;
    e = 1'b0;
    if (n == 0) d = 1'b1;
    else if (n > int'(DEPTH)) e = 1'b1;
    else begin
      d = 1'b1;
      for (int i = 0; i < n; i++) w.push_back({AW'(i), s[2 + 2 * i], s[3 + 2 * i]});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    n = 0;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      load_req = ($urandom_range(3) == 0);
      @(negedge clk);
    end
    load_req = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_pct);
    foreach (s[i]) send_byte(s[i], gap_pct);
    in_valid = 1'b0;
  endtask

  task automatic restart();
    if (done || err) begin
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      check("restart_in_ready", 32'(in_ready), 32'd1);
      check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
      check("restart_done", 32'(done), 32'd0);
      check("restart_err", 32'(err), 32'd0);
      check("restart_addr", 32'(ram_addr), 32'd0);
    end
    got.delete();
    last_we_cyc = -1;
    done_rise   = -1;
  endtask

  task automatic run_expect(input logic [7:0] s[$], input int gap_pct, input wr_t ew[$],
                            input bit ed, input bit ee, input string name);
    int n;
    restart();
    send_stream(s, gap_pct);
    n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) check({name, "_end_timeout"}, 32'(done | err), 32'd1);
    repeat (3) @(negedge clk);
    check({name, "_nwrites"}, 32'(got.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < got.size(); i++) begin
      check({name, "_addr"}, 32'(got[i].a), 32'(ew[i].a));
      check({name, "_data"}, 32'(got[i].d), 32'(ew[i].d));
    end
    check({name, "_done"}, 32'(done), 32'(ed));
    check({name, "_err"}, 32'(err), 32'(ee));
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!ed));
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_final_addr"}, 32'(ram_addr), ed ? 32'(ew.size() % DEPTH) : 32'd0);
    if (ed && ew.size() > 0) check({name, "_cpu_rst_timing"}, 32'(done_rise - last_we_cyc), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_ram_we"}, 32'(ram_we), 32'd0);
    check({name, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({name, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [7];
    logic [7:0]  s[$];
    wr_t         ew[$];
    bit          ed;
    bit          ee;
    int          n;
    int          r;
    int          gap;

    tbl[0] = '{8, '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01}, 1'b1, 1'b0, 3,
               '{16'h1234, 16'hABCD, 16'h0001}, 0};
    tbl[1] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 0,
               '{16'h0, 16'h0, 16'h0}, 0};
    tbl[2] = '{2, '{8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0,
               '{16'h0, 16'h0, 16'h0}, 0};
    tbl[3] = '{4, '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1,
               '{16'hBEEF, 16'h0, 16'h0}, 0};
    tbl[4] = '{2, '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0,
               '{16'h0, 16'h0, 16'h0}, 0};
    tbl[5] = '{8, '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01}, 1'b1, 1'b0, 3,
               '{16'h1234, 16'hABCD, 16'h0001}, 40};
    tbl[6] = '{6, '{8'h00, 8'h02, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h00, 8'h00}, 1'b1, 1'b0, 2,
               '{16'h55AA, 16'h0FF0, 16'h0}, 25};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // Table vectors
    for (int v = 0; v < 7; v++) begin
      s  = {};
      ew = {};
      for (int i = 0; i < tbl[v].nb; i++) s.push_back(tbl[v].b[i]);
      for (int i = 0; i < tbl[v].nw; i++) ew.push_back({AW'(i), tbl[v].w[i]});
      run_expect(s, tbl[v].gap, ew, tbl[v].done_e, tbl[v].err_e, $sformatf("tbl%0d", v));
    end

    // Full depth: N = 16, data equals address, address wraps to 0
    s = {8'h00, 8'h10};
    for (int i = 0; i < 16; i++) begin
      s.push_back(8'h00);
      s.push_back(8'(i));
    end
    model(s, ew, ed, ee);
    run_expect(s, 0, ew, ed, ee, "full_depth");

    // Reset after the 3rd data byte, then reload
    restart();
    s = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    send_stream(s, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    s = {8'h00, 8'h01, 8'h55, 8'hAA};
    model(s, ew, ed, ee);
    run_expect(s, 0, ew, ed, ee, "reload");

    // Randomized loads with gaps and ignored load_req pulses
    for (int t = 0; t < 12; t++) begin
      r = int'($urandom_range(9));
      if (r == 0) n = 0;
      else if (r == 1) n = int'($urandom_range(17, 65535));
      else n = int'($urandom_range(1, 16));
      s = {8'(n >> 8), 8'(n)};
      if (n <= int'(DEPTH)) begin
        for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
      end
      gap = int'($urandom_range(50));
      model(s, ew, ed, ee);
      run_expect(s, gap, ew, ed, ee, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
